// File: rtl/pong_timing_pkg.sv
// Shared horizontal/vertical timing constants and count type for the Pong video chain.
// The V-side values are held here for the vertical counter that consumes VCLK_EN.
package pong_timing_pkg;
   localparam int H_TOTAL_DEF      = 455;
   localparam int H_BLANK_END_DEF  = 80;
   localparam int H_SYNC_START_DEF = 32;
   localparam int H_SYNC_END_DEF   = 64;

   localparam int V_TOTAL_DEF      = 262;
   localparam int V_BLANK_END_DEF  = 16;
   localparam int V_SYNC_START_DEF = 4;
   localparam int V_SYNC_END_DEF   = 8;

   typedef logic [8:0] hcount_t;

   // Wrap is a compare against the last count, never a power-of-two modulo.
   function automatic hcount_t hcount_next(input hcount_t h, input hcount_t h_last);
      return (h == h_last) ? hcount_t'(0) : h + 9'd1;
   endfunction
endpackage

// File: rtl/sync_counter4.sv
// Synchronous SN7493 replacement: 4-bit up-counter, enable, sync clear, carry-out.
// Count updates on the clock edge; carry-out is combinational (en & q==15) for chaining.
module sync_counter4 (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_en,
   input  logic       i_clr,
   output logic [3:0] o_q,
   output logic       o_co
);
   logic [3:0] r_q;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_q <= 4'd0;
      end else if (i_clr) begin
         r_q <= 4'd0;
      end else if (i_en) begin
         r_q <= r_q + 4'd1;
      end
   end

   assign o_q  = r_q;
   assign o_co = i_en & (r_q == 4'hF);
endmodule

// File: rtl/pong_hcounter.sv
// Pong horizontal timing chain: H count, reset/blank/sync flags and line tick; optional LINE_COUNT via PONG_HCOUNTER_LINE_COUNT_EN.
// Zero latency: H and every flag update on the same CLK_DRV edge; VCLK_EN is a single-cycle pulse on the wrap edge.
// No backpressure: advances only on CLK_EN, holds otherwise.
module pong_hcounter
   import pong_timing_pkg::*;
#(
   parameter int H_TOTAL      = H_TOTAL_DEF,
   parameter int H_BLANK_END  = H_BLANK_END_DEF,
   parameter int H_SYNC_START = H_SYNC_START_DEF,
   parameter int H_SYNC_END   = H_SYNC_END_DEF
) (
   input  logic       i_clk_drv,
   input  logic       i_rst_n,
   input  logic       i_clk_en,
   output logic [8:0] o_h,
   output logic       o_hreset,
   output logic       o_hreset_n,
   output logic       o_hblank,
   output logic       o_hblank_n,
   output logic       o_hsync,
   output logic       o_hsync_n,
   output logic       o_vclk_en
`ifdef PONG_HCOUNTER_LINE_COUNT_EN
   ,
   output logic [15:0] o_line_count
`endif
);
   if (!(H_SYNC_START < H_SYNC_END && H_SYNC_END <= H_BLANK_END &&
         H_BLANK_END < H_TOTAL && H_TOTAL <= 512)) begin : g_bad_params
      $error("pong_hcounter: illegal horizontal timing parameters");
   end

   localparam hcount_t LP_H_LAST     = hcount_t'(H_TOTAL - 1);
   localparam hcount_t LP_BLANK_END  = hcount_t'(H_BLANK_END);
   localparam hcount_t LP_SYNC_START = hcount_t'(H_SYNC_START);
   localparam hcount_t LP_SYNC_END   = hcount_t'(H_SYNC_END);

   logic [3:0] w_q_lo;
   logic [3:0] w_q_hi;
   logic       w_co_lo;
   logic       w_co_hi;
   logic       r_h256;
   hcount_t    w_h;
   hcount_t    w_h_next;
   logic       w_wrap;
   logic       w_clr;

   assign w_h    = {r_h256, w_q_hi, w_q_lo};
   assign w_wrap = (w_h == LP_H_LAST);
   assign w_clr  = i_clk_en & w_wrap;

   // 1H..8H and 16H..128H, chained by carry instead of ripple clocking.
   sync_counter4 u_cnt_lo (
      .i_clk   (i_clk_drv),
      .i_rst_n (i_rst_n),
      .i_en    (i_clk_en),
      .i_clr   (w_clr),
      .o_q     (w_q_lo),
      .o_co    (w_co_lo)
   );

   sync_counter4 u_cnt_hi (
      .i_clk   (i_clk_drv),
      .i_rst_n (i_rst_n),
      .i_en    (w_co_lo),
      .i_clr   (w_clr),
      .o_q     (w_q_hi),
      .o_co    (w_co_hi)
   );

   always_ff @(posedge i_clk_drv) begin
      if (!i_rst_n) begin
         r_h256 <= 1'b0;
      end else if (w_clr) begin
         r_h256 <= 1'b0;
      end else if (w_co_hi) begin
         r_h256 <= ~r_h256;
      end
   end

   // Flags are decoded from the value H is about to take so they land on the same edge.
   assign w_h_next = i_clk_en ? hcount_next(w_h, LP_H_LAST) : w_h;

   logic w_hreset_nx;
   logic w_hblank_nx;
   logic w_hsync_nx;

   assign w_hreset_nx = (w_h_next == LP_H_LAST);
   assign w_hblank_nx = (w_h_next < LP_BLANK_END);
   assign w_hsync_nx  = (w_h_next >= LP_SYNC_START) && (w_h_next < LP_SYNC_END);

   logic r_hreset;
   logic r_hreset_n;
   logic r_hblank;
   logic r_hblank_n;
   logic r_hsync;
   logic r_hsync_n;
   logic r_vclk_en;

   always_ff @(posedge i_clk_drv) begin
      if (!i_rst_n) begin
         r_hreset   <= 1'b0;
         r_hreset_n <= 1'b1;
         r_hblank   <= 1'b1;
         r_hblank_n <= 1'b0;
         r_hsync    <= 1'b0;
         r_hsync_n  <= 1'b1;
         r_vclk_en  <= 1'b0;
      end else begin
         r_hreset   <= w_hreset_nx;
         r_hreset_n <= ~w_hreset_nx;
         r_hblank   <= w_hblank_nx;
         r_hblank_n <= ~w_hblank_nx;
         r_hsync    <= w_hsync_nx;
         r_hsync_n  <= ~w_hsync_nx;
         r_vclk_en  <= w_clr;
      end
   end

   assign o_h        = w_h;
   assign o_hreset   = r_hreset;
   assign o_hreset_n = r_hreset_n;
   assign o_hblank   = r_hblank;
   assign o_hblank_n = r_hblank_n;
   assign o_hsync    = r_hsync;
   assign o_hsync_n  = r_hsync_n;
   assign o_vclk_en  = r_vclk_en;

`ifdef PONG_HCOUNTER_LINE_COUNT_EN
   logic [15:0] r_line_count;

   always_ff @(posedge i_clk_drv) begin
      if (!i_rst_n) begin
         r_line_count <= 16'd0;
      end else if (w_clr) begin
         r_line_count <= r_line_count + 16'd1;
      end
   end

   assign o_line_count = r_line_count;
`endif
endmodule

// File: tb/tb_pong_hcounter.sv
// Directed bench for pong_hcounter: reset, free run, enable gating, mid-line reset, optional line count.
module tb_pong_hcounter;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b1;
   logic [8:0] h;
   logic       hreset, hreset_n, hblank, hblank_n, hsync, hsync_n, vclk_en;
`ifdef PONG_HCOUNTER_LINE_COUNT_EN
   logic [15:0] line_count;
   int          exp_lc = 0;
`endif

   int   checks = 0;
   int   failures = 0;
   int   exp_h = 0;
   logic exp_v = 1'b0;

   always #5 clk = ~clk;

   pong_hcounter dut (
      .i_clk_drv  (clk),
      .i_rst_n    (rst_n),
      .i_clk_en   (en),
      .o_h        (h),
      .o_hreset   (hreset),
      .o_hreset_n (hreset_n),
      .o_hblank   (hblank),
      .o_hblank_n (hblank_n),
      .o_hsync    (hsync),
      .o_hsync_n  (hsync_n),
      .o_vclk_en  (vclk_en)
`ifdef PONG_HCOUNTER_LINE_COUNT_EN
      ,
      .o_line_count (line_count)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Called at a negedge: drive inputs, advance one edge, check outputs at the next negedge.
   task automatic cyc(input logic r, input logic e);
      logic hr, hb, hs;
      rst_n = r;
      en    = e;
      @(posedge clk);
      if (!r) begin
         exp_h = 0;
         exp_v = 1'b0;
      end else if (e) begin
         exp_v = (exp_h == 454);
         exp_h = exp_v ? 0 : exp_h + 1;
      end else begin
         exp_v = 1'b0;
      end
`ifdef PONG_HCOUNTER_LINE_COUNT_EN
      if (!r) exp_lc = 0;
      else if (exp_v) exp_lc = (exp_lc + 1) % 65536;
`endif
      hr = (exp_h == 454);
      hb = (exp_h < 80);
      hs = (exp_h >= 32) && (exp_h < 64);
      @(negedge clk);
      chk("h",        int'(h),        exp_h);
      chk("hreset",   int'(hreset),   int'(hr));
      chk("hreset_n", int'(hreset_n), int'(!hr));
      chk("hblank",   int'(hblank),   int'(hb));
      chk("hblank_n", int'(hblank_n), int'(!hb));
      chk("hsync",    int'(hsync),    int'(hs));
      chk("hsync_n",  int'(hsync_n),  int'(!hs));
      chk("vclk_en",  int'(vclk_en),  int'(exp_v));
`ifdef PONG_HCOUNTER_LINE_COUNT_EN
      chk("line_count", int'(line_count), exp_lc);
`endif
   endtask

   initial begin
      int first, second, npulse, nsync, nblank, nreset;

      @(negedge clk);
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1);
      chk("reset_h", int'(h), 0);
      chk("reset_hblank", int'(hblank), 1);

      // Free run
      first = 0; second = 0; npulse = 0; nsync = 0; nblank = 0; nreset = 0;
      for (int k = 1; k <= 1000; k++) begin
         cyc(1'b1, 1'b1);
         if (vclk_en) begin
            npulse++;
            if (first == 0) first = k; else if (second == 0) second = k;
         end
         if (k <= 455) begin
            nsync  += int'(hsync);
            nblank += int'(hblank);
            nreset += int'(hreset);
         end
      end
      chk("run_vclk_first",  first,  455);
      chk("run_vclk_second", second, 910);
      chk("run_vclk_count",  npulse, 2);
      chk("run_hsync_width", nsync,  32);
      chk("run_hblank_width", nblank, 80);
      chk("run_hreset_count", nreset, 1);

      // Enable every second cycle
      cyc(1'b0, 1'b1);
      first = 0; second = 0; npulse = 0;
      for (int k = 1; k <= 2000; k++) begin
         cyc(1'b1, (k % 2) == 1);
         if (vclk_en) begin
            npulse++;
            if (first == 0) first = k; else if (second == 0) second = k;
         end
      end
      chk("gate_vclk_first",  first,  909);
      chk("gate_vclk_second", second, 1819);
      chk("gate_vclk_count",  npulse, 2);

      // Mid-line reset at H=200
      cyc(1'b0, 1'b1);
      for (int k = 0; k < 200; k++) cyc(1'b1, 1'b1);
      chk("mid_h_before", int'(h), 200);
      cyc(1'b0, 1'b1);
      chk("mid_h_after", int'(h), 0);
      chk("mid_hblank_after", int'(hblank), 1);
      chk("mid_vclk_after", int'(vclk_en), 0);
      first = 0;
      for (int k = 1; k <= 500; k++) begin
         cyc(1'b1, 1'b1);
         if (vclk_en && first == 0) first = k;
      end
      chk("mid_vclk_first", first, 455);

`ifdef PONG_HCOUNTER_LINE_COUNT_EN
      cyc(1'b0, 1'b1);
      for (int k = 0; k < 3 * 455; k++) cyc(1'b1, 1'b1);
      chk("lc_three_lines", int'(line_count), 3);
      force dut.r_line_count = 16'hFFFF;
      #1;
      release dut.r_line_count;
      exp_lc = 65535;
      for (int k = 0; k < 455; k++) cyc(1'b1, 1'b1);
      chk("lc_wrap", int'(line_count), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
